// File: rtl/operand_fetch_unit.sv
// Operand fetch between decode and execute: regfile addressing, RAW forwarding,
// per-register scoreboard of in-flight writers, registered handshake to execute.
module operand_fetch_unit #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            dec_i_valid,
  output logic            dec_o_ready,
  input  logic [4:0]      dec_i_rs1,
  input  logic [4:0]      dec_i_rs2,
  input  logic [4:0]      dec_i_rd,
  input  logic            dec_i_use_rs1,
  input  logic            dec_i_use_rs2,
  input  logic            dec_i_rd_wen,
  output logic [4:0]      rf_o_rs1,
  output logic [4:0]      rf_o_rs2,
  input  logic [XLEN-1:0] rf_i_valA,
  input  logic [XLEN-1:0] rf_i_valB,
  input  logic            ex_i_wen,
  input  logic            mem_i_wen,
  input  logic            wb_i_wen,
  input  logic [4:0]      ex_i_rd,
  input  logic [4:0]      mem_i_rd,
  input  logic [4:0]      wb_i_rd,
  input  logic [XLEN-1:0] ex_i_data,
  input  logic [XLEN-1:0] mem_i_data,
  input  logic [XLEN-1:0] wb_i_data,
  input  logic            ex_i_data_ok,
  input  logic            mem_i_data_ok,
  input  logic            ret_i_valid,
  input  logic [4:0]      ret_i_rd,
  input  logic            sq_i_valid,
  input  logic [4:0]      sq_i_rd,
  input  logic            flush_i,
  output logic            ex_o_valid,
  input  logic            ex_i_ready,
  output logic [XLEN-1:0] ex_o_valA,
  output logic [XLEN-1:0] ex_o_valB,
  output logic [4:0]      ex_o_rd,
  output logic            ex_o_rd_wen
);

  typedef struct packed {
    logic            ok;
    logic [XLEN-1:0] val;
  } src_t;

  logic [CNT_W-1:0] pend_q [32];
  logic [CNT_W-1:0] pend_d [32];

  logic            ex_valid_q;
  logic [XLEN-1:0] valA_q, valB_q;
  logic [4:0]      rd_q;
  logic            rd_wen_q;

  src_t src1, src2;
  logic rd_ok, can_issue, issue;

  // Youngest matching stage wins; a pending writer with no visible stage is in our own output register.
  function automatic src_t resolve(input logic use_rs, input logic [4:0] rs,
                                   input logic pending, input logic [XLEN-1:0] rf_val);
    src_t r;
    r.ok  = 1'b1;
    r.val = rf_val;
    if (rs == 5'd0) begin
      r.val = '0;
    end else if (ex_i_wen && ex_i_rd == rs) begin
      r.val = ex_i_data;
      r.ok  = ex_i_data_ok;
    end else if (mem_i_wen && mem_i_rd == rs) begin
      r.val = mem_i_data;
      r.ok  = mem_i_data_ok;
    end else if (wb_i_wen && wb_i_rd == rs) begin
      r.val = wb_i_data;
    end else if (pending) begin
      r.ok = 1'b0;
    end
    if (!use_rs) r.ok = 1'b1;
    return r;
  endfunction

  always_comb begin
    src1 = resolve(dec_i_use_rs1, dec_i_rs1, pend_q[dec_i_rs1] != '0, rf_i_valA);
    src2 = resolve(dec_i_use_rs2, dec_i_rs2, pend_q[dec_i_rs2] != '0, rf_i_valB);
  end

  assign rf_o_rs1 = dec_i_rs1;
  assign rf_o_rs2 = dec_i_rs2;

  assign rd_ok       = !dec_i_rd_wen || dec_i_rd == 5'd0 || pend_q[dec_i_rd] != '1;
  assign can_issue   = src1.ok && src2.ok && rd_ok && (!ex_valid_q || ex_i_ready) && !flush_i;
  assign issue       = dec_i_valid && can_issue;
  assign dec_o_ready = can_issue;

  logic             sb_inc;
  logic [CNT_W:0]   sb_up;
  logic [CNT_W:0]   sb_dn;

  // NOTE: every combinational output gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    sb_inc = 1'b0;
    sb_up  = '0;
    sb_dn  = '0;
    for (int r = 0; r < 32; r++) pend_d[r] = '0;
    for (int r = 1; r < 32; r++) begin
      sb_inc = issue && dec_i_rd_wen && dec_i_rd == 5'(r);
      sb_up  = {1'b0, pend_q[r]} + (CNT_W+1)'(sb_inc);
      sb_dn  = (CNT_W+1)'(ret_i_valid && ret_i_rd == 5'(r))
             + (CNT_W+1)'(sq_i_valid && sq_i_rd == 5'(r));
      // Decrementing past zero is a protocol error upstream; clamp rather than wrap.
      pend_d[r] = (sb_dn > sb_up) ? '0 : CNT_W'(sb_up - sb_dn);
    end
  end

  // NOTE: the counter array is a flop bank, not a RAM, so it is reset with the rest of the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < 32; r++) pend_q[r] <= '0;
    end else begin
      for (int r = 0; r < 32; r++) pend_q[r] <= pend_d[r];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid_q <= 1'b0;
      valA_q     <= '0;
      valB_q     <= '0;
      rd_q       <= '0;
      rd_wen_q   <= 1'b0;
    end else if (issue) begin
      ex_valid_q <= 1'b1;
      valA_q     <= src1.val;
      valB_q     <= src2.val;
      rd_q       <= dec_i_rd;
      rd_wen_q   <= dec_i_rd_wen;
    end else if (flush_i || ex_i_ready) begin
      ex_valid_q <= 1'b0;
    end
  end

  assign ex_o_valid  = ex_valid_q;
  assign ex_o_valA   = valA_q;
  assign ex_o_valB   = valB_q;
  assign ex_o_rd     = rd_q;
  assign ex_o_rd_wen = rd_wen_q;

endmodule

// File: doc/operand_fetch_unit.md
Name: operand_fetch_unit

Overview:
- Reader-side counterpart of the 64-bit register file: drives the regfile read addresses, resolves RAW hazards and forwards results, then hands operands to execute.
- Keeps a per-register scoreboard of in-flight writers and stalls decode until every source operand is valid.
- Sits between decode and execute in the five-stage RV64 pipeline, with a registered valid/ready handshake on both sides.

Parameters:
- XLEN, 64, data width.
- CNT_W, 2, width of each scoreboard pending counter; the maximum number of in-flight writers per register is 2^CNT_W-1.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- dec_i_valid  in  1  decode has an instruction.
- dec_o_ready  out  1  unit accepts the decode instruction this cycle.
- dec_i_rs1, dec_i_rs2, dec_i_rd  in  5 each  register indices.
- dec_i_use_rs1, dec_i_use_rs2, dec_i_rd_wen  in  1 each  operand-use and write flags.
- rf_o_rs1, rf_o_rs2  out  5 each  regfile read addresses; combinational copies of dec_i_rs1/rs2.
- rf_i_valA, rf_i_valB  in  XLEN each  regfile read data (combinational).
- ex_i_wen, mem_i_wen, wb_i_wen  in  1 each  stage holds a register writer.
- ex_i_rd, mem_i_rd, wb_i_rd  in  5 each  destination register of that stage.
- ex_i_data, mem_i_data, wb_i_data  in  XLEN each  result data of that stage.
- ex_i_data_ok, mem_i_data_ok  in  1 each  result is available (0 for a load in EX, or while MEM waits).
- ret_i_valid, ret_i_rd  in  1, 5  writer retired at writeback.
- sq_i_valid, sq_i_rd  in  1, 5  issued writer squashed by flush.
- flush_i  in  1  kill the instruction in the output register.
- ex_o_valid  out  1  operands valid to execute.
- ex_i_ready  in  1  execute accepts.
- ex_o_valA, ex_o_valB  out  XLEN each  resolved operands.
- ex_o_rd, ex_o_rd_wen  out  5, 1  passed through.

Behaviour:
- Reset (rst=0, asynchronous): ex_o_valid=0, ex_o_valA=ex_o_valB=0, ex_o_rd=0, ex_o_rd_wen=0, all 32 scoreboard counters cleared to 0.
- Per-source resolution, applied to rs1 and rs2 independently. A source is "ok" when any of these holds:
  - its use flag is 0;
  - rs==0, and the value is then forced to 0;
  - pend[rs]==0, and the value comes from the regfile;
  - it matches a forwarding stage under the priority below.
- Forwarding priority is youngest first: EX (wen && rd==rs), then MEM, then WB.
  - The first matching stage supplies the value.
  - If the first matching stage is EX or MEM with data_ok=0, the source is not ok.
  - WB data is always ok.
- If pend[rs]!=0 and no stage matches (the writer sits in this unit's own output register), the source is not ok.
- Overflow guard: rd_ok = !dec_i_rd_wen || rd==0 || pend[rd] != all-ones.
- Issue condition: issue = dec_i_valid && src1_ok && src2_ok && rd_ok && (!ex_o_valid || ex_i_ready) && !flush_i.
  - dec_o_ready equals issue with the dec_i_valid term removed.
- Output register latency is one cycle. On issue, load the operands, rd and rd_wen, and set ex_o_valid=1.
  - On a handshake with no new issue, clear ex_o_valid.
  - When stalled with no handshake, hold every output stable.
  - On flush_i, clear ex_o_valid at the next edge.
  - flush_i does not touch the counters; squashed writers are reported on sq_i.
- Scoreboard update, per register r, each cycle: pend[r] += (issue && rd_wen && rd==r && r!=0) − (ret_i_valid && ret_i_rd==r) − (sq_i_valid && sq_i_rd==r).
  - Increment and decrement in the same cycle: net change 0.
  - Both decrements in the same cycle: −2.
  - pend[0] stays 0 at all times.
  - Decrementing a zero counter is illegal: the bench asserts it never happens, and the RTL saturates at 0.
- A WB write and a decode read of the same register in the same cycle: WB forwarding supplies the new value, so there is no regfile write-before-read dependence.

Test Plan:
- Reset, then issue addi x1 (rd_wen=1) -> one cycle later ex_o_valid=1 and pend[1]=1. Then ret_i_valid with rd=1 -> pend[1]=0.
- Back-to-back dependency: x5 sits in EX with data 0x1234 and data_ok=1; decode uses rs1=5 -> ex_o_valA=0x1234 and no stall. The same case with MEM holding 0xAAAA for x5 -> the EX value wins.
- Load-use: EX holds a load to x7 (data_ok=0); decode uses rs2=7 -> dec_o_ready=0 for one cycle. Next cycle MEM has data_ok=1 with 0xBEEF -> issue with ex_o_valB=0xBEEF.
- rs1=0 with EX writing x0 (wen=1, data 0x55) -> ex_o_valA=0 and no stall. An issue with rd=0 -> pend[0] stays 0.
- Three in-flight writers to x3 (pend=3); a fourth writer of x3 -> stalled until ret_i_rd=3. An issue and a retire of x3 in the same cycle -> pend unchanged.
- Back-pressure: ex_i_ready=0 for 3 cycles while valid -> outputs stable and dec_o_ready=0. flush_i=1 -> ex_o_valid=0 next edge. Assert rst mid-stall -> all outputs and counters 0 immediately.
